// File: rtl/frontend_cmd_arbiter_if.sv
// Requester-side and scheduler-side command/write-data bundle for frontend_cmd_arbiter.
// The arbiter connects through the slave modport; the surrounding logic drives the master modport.
interface frontend_cmd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CMD_W   = 32,
  parameter int DATA_W  = 128
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*CMD_W-1:0]  req_cmd;
  logic [NUM_REQ-1:0]        req_is_write;
  logic [NUM_REQ-1:0]        req_wvalid;
  logic [NUM_REQ-1:0]        req_wready;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_wlast;

  logic                      out_cmd_valid;
  logic                      out_cmd_ready;
  logic [CMD_W-1:0]          out_cmd;
  logic [ID_W-1:0]           out_req_id;
  logic                      out_wvalid;
  logic                      out_wready;
  logic [DATA_W-1:0]         out_wdata;
  logic                      out_wlast;

  modport slave (
    input  req_valid, req_cmd, req_is_write, req_wvalid, req_wdata, req_wlast,
    input  out_cmd_ready, out_wready,
    output req_ready, req_wready,
    output out_cmd_valid, out_cmd, out_req_id, out_wvalid, out_wdata, out_wlast
  );

  modport master (
    output req_valid, req_cmd, req_is_write, req_wvalid, req_wdata, req_wlast,
    output out_cmd_ready, out_wready,
    input  req_ready, req_wready,
    input  out_cmd_valid, out_cmd, out_req_id, out_wvalid, out_wdata, out_wlast
  );
endinterface

// File: rtl/frontend_cmd_arbiter.sv
// Round-robin frontend command arbiter with write-burst lock; 0-cycle cmd path, or 1-cycle slice
// when FE_ARB_OUT_REG_EN is defined. A stalled grant is held; no re-arbitration until handshake.
module frontend_cmd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CMD_W   = 32,
  parameter int DATA_W  = 128
) (
  input  logic                   clk,
  input  logic                   rst_n,
  frontend_cmd_arbiter_if.slave  bus,
  output logic                   busy
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ST_ARB, ST_WDATA} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] wr_owner_q, wr_owner_d;
  logic [ID_W-1:0] held_g_q, held_g_d;
  logic            held_vld_q, held_vld_d;

  logic [CMD_W-1:0]  cmd_a   [NUM_REQ];
  logic [DATA_W-1:0] wdata_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign cmd_a[i]   = bus.req_cmd[i*CMD_W +: CMD_W];
    assign wdata_a[i] = bus.req_wdata[i*DATA_W +: DATA_W];
  end

  // Rotating priority scan: descending k so the entry closest to rr_ptr wins.
  logic [ID_W-1:0] scan_g;
  logic            scan_hit;
  always_comb begin
    int idx;
    scan_g   = '0;
    scan_hit = 1'b0;
    idx      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req_valid[idx]) begin
        scan_hit = 1'b1;
        scan_g   = ID_W'(idx);
      end
    end
  end

  logic [ID_W-1:0] g;
  logic            gnt_vld;
  logic [ID_W-1:0] nxt_ptr;
  assign g       = held_vld_q ? held_g_q : scan_g;
  assign gnt_vld = held_vld_q | scan_hit;
  assign nxt_ptr = (g == ID_W'(NUM_REQ - 1)) ? '0 : g + ID_W'(1);

  logic slot_ok;
  logic wdata_ok;
  logic cmd_take;

`ifdef FE_ARB_OUT_REG_EN
  logic             s_vld_q;
  logic [CMD_W-1:0] s_cmd_q;
  logic [ID_W-1:0]  s_id_q;

  assign slot_ok  = ~s_vld_q | bus.out_cmd_ready;
  // Data waits until its command has left the slice.
  assign wdata_ok = ~s_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_vld_q <= 1'b0;
      s_cmd_q <= '0;
      s_id_q  <= '0;
    end else if (cmd_take) begin
      s_vld_q <= 1'b1;
      s_cmd_q <= cmd_a[g];
      s_id_q  <= g;
    end else if (s_vld_q && bus.out_cmd_ready) begin
      s_vld_q <= 1'b0;
    end
  end
`else
  assign slot_ok  = bus.out_cmd_ready;
  assign wdata_ok = 1'b1;
`endif

  assign cmd_take = (state_q == ST_ARB) && gnt_vld && slot_ok;

  logic [NUM_REQ-1:0] rdy_vec, wrdy_vec;
  logic               cmd_vld, wvld, wlst, busy_c;
  logic [CMD_W-1:0]   cmd_dat;
  logic [ID_W-1:0]    id_dat;
  logic [DATA_W-1:0]  wdat;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    wr_owner_d = wr_owner_q;
    held_g_d   = held_g_q;
    held_vld_d = held_vld_q;
    rdy_vec    = '0;
    wrdy_vec   = '0;
    cmd_vld    = 1'b0;
    cmd_dat    = '0;
    id_dat     = '0;
    wvld       = 1'b0;
    wdat       = '0;
    wlst       = 1'b0;
    busy_c     = 1'b0;

    unique case (state_q)
      ST_ARB: begin
        if (gnt_vld) begin
          rdy_vec[g] = slot_ok;
`ifndef FE_ARB_OUT_REG_EN
          cmd_vld = 1'b1;
          cmd_dat = cmd_a[g];
          id_dat  = g;
`endif
        end
        if (cmd_take) begin
          rr_ptr_d   = nxt_ptr;
          held_vld_d = 1'b0;
          if (bus.req_is_write[g]) begin
            wr_owner_d = g;
            state_d    = ST_WDATA;
          end
        end else if (gnt_vld) begin
          held_vld_d = 1'b1;
          held_g_d   = g;
        end
      end
      ST_WDATA: begin
        busy_c = 1'b1;
        if (wdata_ok) begin
          wvld               = bus.req_wvalid[wr_owner_q];
          wdat               = wdata_a[wr_owner_q];
          wlst               = bus.req_wlast[wr_owner_q];
          wrdy_vec[wr_owner_q] = bus.out_wready;
        end
        if (wvld && bus.out_wready && wlst) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase

`ifdef FE_ARB_OUT_REG_EN
    cmd_vld = s_vld_q;
    cmd_dat = s_cmd_q;
    id_dat  = s_id_q;
`endif

    // Combinational outputs stay quiet while reset is asserted.
    if (!rst_n) begin
      rdy_vec  = '0;
      wrdy_vec = '0;
      cmd_vld  = 1'b0;
      cmd_dat  = '0;
      id_dat   = '0;
      wvld     = 1'b0;
      wdat     = '0;
      wlst     = 1'b0;
      busy_c   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ARB;
      rr_ptr_q   <= '0;
      wr_owner_q <= '0;
      held_g_q   <= '0;
      held_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_owner_q <= wr_owner_d;
      held_g_q   <= held_g_d;
      held_vld_q <= held_vld_d;
    end
  end

  assign bus.req_ready     = rdy_vec;
  assign bus.req_wready    = wrdy_vec;
  assign bus.out_cmd_valid = cmd_vld;
  assign bus.out_cmd       = cmd_dat;
  assign bus.out_req_id    = id_dat;
  assign bus.out_wvalid    = wvld;
  assign bus.out_wdata     = wdat;
  assign bus.out_wlast     = wlst;
  assign busy              = busy_c;
endmodule

// File: tb/tb_frontend_cmd_arbiter.sv
// Directed bench for frontend_cmd_arbiter (default combinational command path).
module tb_frontend_cmd_arbiter;
  localparam int NUM_REQ = 4;
  localparam int CMD_W   = 32;
  localparam int DATA_W  = 128;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  always #5 clk = ~clk;

  frontend_cmd_arbiter_if #(.NUM_REQ(NUM_REQ), .CMD_W(CMD_W), .DATA_W(DATA_W)) bus ();

  frontend_cmd_arbiter #(.NUM_REQ(NUM_REQ), .CMD_W(CMD_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CMD_W-1:0] cmd_of(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h11;
  endfunction

  function automatic logic [DATA_W-1:0] beat_of(input int r, input int b);
    return {96'h0, 16'hDA7A, 8'(r), 8'(b)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int r, input int b, input int nb);
    bus.req_wdata[r*DATA_W +: DATA_W] = beat_of(r, b);
    bus.req_wlast[r]  = (b == nb - 1);
    bus.req_wvalid[r] = 1'b1;
  endtask

  // Drives a burst from requester r; pat[c] is out_wready in WDATA cycle c.
  task automatic burst(input int r, input int nb, input logic [7:0] pat, input int ncyc,
                       input logic chk_hold);
    int bi;
    bi = 0;
    for (int c = 0; c < ncyc; c++) begin
      bus.out_wready = pat[c];
      set_beat(r, bi, nb);
      @(negedge clk);
      check($sformatf("burst%0d_busy_c%0d", r, c), 128'(busy), 128'(1));
      check($sformatf("burst%0d_wvalid_c%0d", r, c), 128'(bus.out_wvalid), 128'(1));
      check($sformatf("burst%0d_wdata_c%0d", r, c), 128'(bus.out_wdata), 128'(beat_of(r, bi)));
      check($sformatf("burst%0d_wlast_c%0d", r, c), 128'(bus.out_wlast), 128'(bi == nb - 1));
      check($sformatf("burst%0d_wready_c%0d", r, c), 128'(bus.req_wready),
            128'(pat[c] ? (4'b0001 << r) : 4'b0000));
      if (chk_hold) begin
        check($sformatf("burst%0d_cmdvld_c%0d", r, c), 128'(bus.out_cmd_valid), 128'(0));
        check($sformatf("burst%0d_reqrdy_c%0d", r, c), 128'(bus.req_ready), 128'(0));
      end
      @(posedge clk);
      if (pat[c]) bi++;
      #1;
    end
    bus.req_wvalid[r] = 1'b0;
    bus.req_wlast[r]  = 1'b0;
    bus.out_wready    = 1'b1;
  endtask

  task automatic chk_cmd(input string name, input logic vld, input int id, input logic [3:0] rdy);
    @(negedge clk);
    check({name, "_vld"}, 128'(bus.out_cmd_valid), 128'(vld));
    check({name, "_id"}, 128'(bus.out_req_id), 128'(vld ? id : 0));
    check({name, "_cmd"}, 128'(bus.out_cmd), 128'(vld ? cmd_of(id) : 32'h0));
    check({name, "_rdy"}, 128'(bus.req_ready), 128'(rdy));
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       cmd_ready;
    logic       exp_vld;
    int         exp_id;
    logic [3:0] exp_ready;
  } vec_t;

  vec_t vt [10];

  initial begin
    vt[0] = '{4'b1111, 1'b1, 1'b1, 0, 4'b0001};
    vt[1] = '{4'b1111, 1'b1, 1'b1, 1, 4'b0010};
    vt[2] = '{4'b1111, 1'b1, 1'b1, 2, 4'b0100};
    vt[3] = '{4'b1111, 1'b1, 1'b1, 3, 4'b1000};
    vt[4] = '{4'b1111, 1'b1, 1'b1, 0, 4'b0001};
    vt[5] = '{4'b0000, 1'b1, 1'b0, 0, 4'b0000};
    vt[6] = '{4'b1001, 1'b1, 1'b1, 3, 4'b1000};
    vt[7] = '{4'b1001, 1'b0, 1'b1, 0, 4'b0000};
    vt[8] = '{4'b1001, 1'b1, 1'b1, 0, 4'b0001};
    vt[9] = '{4'b0001, 1'b1, 1'b1, 0, 4'b0001};

    rst_n             = 1'b0;
    bus.req_valid     = 4'b1111;
    bus.req_is_write  = 4'b1111;
    bus.req_wvalid    = 4'b1111;
    bus.req_wlast     = 4'b1111;
    bus.req_wdata     = '1;
    bus.req_cmd       = '0;
    bus.out_cmd_ready = 1'b1;
    bus.out_wready    = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) bus.req_cmd[i*CMD_W +: CMD_W] = cmd_of(i);

    // Reset with everything requesting: outputs must be quiet.
    repeat (2) @(negedge clk);
    check("rst_cmd_valid", 128'(bus.out_cmd_valid), 128'(0));
    check("rst_req_ready", 128'(bus.req_ready), 128'(0));
    check("rst_req_wready", 128'(bus.req_wready), 128'(0));
    check("rst_out_cmd", 128'(bus.out_cmd), 128'(0));
    check("rst_out_req_id", 128'(bus.out_req_id), 128'(0));
    check("rst_out_wvalid", 128'(bus.out_wvalid), 128'(0));
    check("rst_out_wdata", 128'(bus.out_wdata), 128'(0));
    check("rst_out_wlast", 128'(bus.out_wlast), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    step();
    rst_n            = 1'b1;
    bus.req_is_write = 4'b0000;
    bus.req_wvalid   = 4'b0000;
    bus.req_wlast    = 4'b0000;
    bus.req_wdata    = '0;

    // Round robin, wrap, idle, hold-under-stall.
    for (int i = 0; i < 10; i++) begin
      bus.req_valid     = vt[i].valid;
      bus.out_cmd_ready = vt[i].cmd_ready;
      chk_cmd($sformatf("vec%0d", i), vt[i].exp_vld, vt[i].exp_id, vt[i].exp_ready);
      step();
    end
    bus.out_cmd_ready = 1'b1;

    // Id 2 write, 4 beats, out_wready 1,0,1,1,1; beat 0 already valid in the grant cycle.
    bus.req_valid    = 4'b0100;
    bus.req_is_write = 4'b0100;
    set_beat(2, 0, 4);
    chk_cmd("wr2_grant", 1'b1, 2, 4'b0100);
    check("wr2_grant_wvalid", 128'(bus.out_wvalid), 128'(0));
    check("wr2_grant_wready", 128'(bus.req_wready), 128'(0));
    check("wr2_grant_busy", 128'(busy), 128'(0));
    step();
    bus.req_valid = 4'b0000;
    burst(2, 4, 8'b0001_1101, 5, 1'b0);
    @(negedge clk);
    check("wr2_done_busy", 128'(busy), 128'(0));
    check("wr2_done_wvalid", 128'(bus.out_wvalid), 128'(0));
    step();

    // Id 1 write while id 2 holds a read; wlast stalled once.
    bus.req_valid    = 4'b0110;
    bus.req_is_write = 4'b0010;
    chk_cmd("wr1_grant", 1'b1, 1, 4'b0010);
    step();
    bus.req_valid = 4'b0100;
    burst(1, 2, 8'b0000_0101, 3, 1'b1);
    chk_cmd("rd2_after_wr1", 1'b1, 2, 4'b0100);
    check("rd2_after_wr1_busy", 128'(busy), 128'(0));
    step();
    bus.req_valid    = 4'b0000;
    bus.req_is_write = 4'b0000;

    // Move rr_ptr to 0 via an id 3 read, then stall id 3 while id 0 joins.
    bus.req_valid = 4'b1000;
    chk_cmd("rd3_pre", 1'b1, 3, 4'b1000);
    step();
    bus.out_cmd_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk_cmd($sformatf("stall3_s%0d", s), 1'b1, 3, 4'b0000);
      step();
      bus.req_valid = 4'b1001;
    end
    bus.out_cmd_ready = 1'b1;
    chk_cmd("stall3_release", 1'b1, 3, 4'b1000);
    step();
    bus.req_valid = 4'b0001;
    chk_cmd("after_stall_id0", 1'b1, 0, 4'b0001);
    step();
    bus.req_valid = 4'b0000;

    // Reset in the middle of an id 1 burst.
    bus.req_valid    = 4'b0010;
    bus.req_is_write = 4'b0010;
    chk_cmd("wr1b_grant", 1'b1, 1, 4'b0010);
    step();
    bus.req_valid = 4'b0000;
    for (int b = 0; b < 2; b++) begin
      set_beat(1, b, 4);
      step();
    end
    set_beat(1, 2, 4);
    #1;
    check("mid_burst_busy", 128'(busy), 128'(1));
    check("mid_burst_wdata", 128'(bus.out_wdata), 128'(beat_of(1, 2)));
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 128'(busy), 128'(0));
    check("rst_mid_wvalid", 128'(bus.out_wvalid), 128'(0));
    check("rst_mid_wready", 128'(bus.req_wready), 128'(0));
    step();
    rst_n            = 1'b1;
    bus.req_wvalid   = 4'b0000;
    bus.req_wlast    = 4'b0000;
    bus.req_is_write = 4'b0000;
    bus.req_valid    = 4'b1111;
    chk_cmd("post_rst_first", 1'b1, 0, 4'b0001);
    check("post_rst_busy", 128'(busy), 128'(0));
    step();
    chk_cmd("post_rst_second", 1'b1, 1, 4'b0010);
    step();
    bus.req_valid = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
